clock_route_config_ctrl: RTL and testbench

CLOCK_ROUTE_CONFIG_CTRL -- requirements
Module: clock_route_config_ctrl

---
 rtl/clock_route_pkg.sv | 25 ++
 rtl/clock_logic_cross_sync_0.sv | 28 ++
 rtl/clock_route_config_ctrl.sv | 171 +++++++++++++++++
 tb/tb_clock_route_config_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_route_pkg.sv
// Shared definitions for the clock-route configuration blocks.
//   route_state_e : sequencing states of the divider configuration controller
//   WAIT_CNT_W    : width of the acknowledge wait counter
//   cfg_is_valid  : legality check for a requested divide setting
package clock_route_pkg;

    localparam int unsigned WAIT_CNT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StUpdReq,
        StUpdRel,
        StEnChk,
        StEnWait,
        StDone
    } route_state_e;

    // Integer part must be non-zero; a fractional part must be a proper fraction.
    function automatic logic cfg_is_valid(input logic [7:0] req_mfi,
                                          input logic [7:0] req_mfn,
                                          input logic [7:0] req_mfd);
        return (req_mfi != 8'd0) && ((req_mfn == 8'd0) || (req_mfn < req_mfd));
    endfunction

endpackage

// File: rtl/clock_logic_cross_sync_0.sv
// Two-flop level synchroniser bringing an asynchronous level into the clock domain.
//   clock        : destination clock
//   async_resetn : asynchronous active-low reset, clears both flops
//   async_in     : asynchronous level input
//   sync_out     : synchronised level, two cycles of latency
module clock_logic_cross_sync_0 (
    input  logic clock,
    input  logic async_resetn,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/clock_route_config_ctrl.sv
// Divider configuration controller. Accepts a divide setting, validates it, presents
// it to the divider and runs an update request/release handshake, then brings the
// divider enable to the requested state. Every handshake wait is bounded.
//   clock, async_resetn           : block clock, asynchronous active-low reset
//   cfg_valid/cfg_ready           : request handshake (ready only when idle)
//   cfg_mfi/cfg_mfn/cfg_mfd       : requested integer/numerator/denominator
//   cfg_enable                    : requested divider enable
//   mfi/mfn/mfd                   : registered divide values to the divider
//   async_update/async_update_ack : update request level and its async acknowledge
//   async_enable/async_enable_ack : enable request level and its async acknowledge
//   busy, done                    : sequence active, one-cycle completion pulse
//   err_cfg, err_timeout          : sticky status of the last request
module clock_route_config_ctrl
    import clock_route_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       clock,
    input  logic       async_resetn,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_mfi,
    input  logic [7:0] cfg_mfn,
    input  logic [7:0] cfg_mfd,
    input  logic       cfg_enable,
    output logic [7:0] mfi,
    output logic [7:0] mfn,
    output logic [7:0] mfd,
    output logic       async_update,
    input  logic       async_update_ack,
    output logic       async_enable,
    input  logic       async_enable_ack,
    output logic       busy,
    output logic       done,
    output logic       err_cfg,
    output logic       err_timeout
);

    localparam logic [WAIT_CNT_W-1:0] TimeoutVal = WAIT_CNT_W'(TIMEOUT_CYCLES);

    route_state_e          state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]            mfi_q, mfi_d, mfn_q, mfn_d, mfd_q, mfd_d;
    logic                  en_target_q, en_target_d;
    logic                  async_update_q, async_update_d;
    logic                  async_enable_q, async_enable_d;
    logic                  err_cfg_q, err_cfg_d;
    logic                  err_timeout_q, err_timeout_d;

    logic upd_ack_sync, en_ack_sync;
    logic accept, req_ok, en_match, wait_state, ack_met, abort;

    clock_logic_cross_sync_0 u_upd_ack_sync (
        .clock        (clock),
        .async_resetn (async_resetn),
        .async_in     (async_update_ack),
        .sync_out     (upd_ack_sync)
    );

    clock_logic_cross_sync_0 u_en_ack_sync (
        .clock        (clock),
        .async_resetn (async_resetn),
        .async_in     (async_enable_ack),
        .sync_out     (en_ack_sync)
    );

    assign accept   = cfg_valid && (state_q == StIdle);
    assign req_ok   = cfg_is_valid(cfg_mfi, cfg_mfn, cfg_mfd);
    assign en_match = (en_ack_sync == en_target_q);

    // Which states wait on an acknowledge, and whether the awaited level is present.
    always_comb begin
        wait_state = 1'b0;
        ack_met    = 1'b0;
        unique case (state_q)
            StUpdReq: begin wait_state = 1'b1; ack_met = upd_ack_sync;  end
            StUpdRel: begin wait_state = 1'b1; ack_met = !upd_ack_sync; end
            StEnWait: begin wait_state = 1'b1; ack_met = en_match;      end
            default:  ;
        endcase
    end

    // An arriving acknowledge wins over a coincident timeout.
    assign abort = wait_state && !ack_met && (cnt_q == TimeoutVal);

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) state_q <= StIdle;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept && req_ok) state_d = StUpdReq;
            StUpdReq: if (ack_met) state_d = StUpdRel; else if (abort) state_d = StIdle;
            StUpdRel: if (ack_met) state_d = StEnChk;  else if (abort) state_d = StIdle;
            StEnChk:  state_d = en_match ? StDone : StEnWait;
            StEnWait: if (ack_met) state_d = StDone;   else if (abort) state_d = StIdle;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
    end

    always_comb begin
        mfi_d          = mfi_q;
        mfn_d          = mfn_q;
        mfd_d          = mfd_q;
        en_target_d    = en_target_q;
        err_cfg_d      = err_cfg_q;
        err_timeout_d  = err_timeout_q;
        async_enable_d = async_enable_q;
        // Registered so the divider sees a glitch-free request level.
        async_update_d = (state_d == StUpdReq);
        if (accept) begin
            if (req_ok) begin
                mfi_d         = cfg_mfi;
                mfn_d         = cfg_mfn;
                mfd_d         = cfg_mfd;
                en_target_d   = cfg_enable;
                err_cfg_d     = 1'b0;
                err_timeout_d = 1'b0;
            end else begin
                err_cfg_d = 1'b1;
            end
        end
        if ((state_q == StEnChk) && !en_match) async_enable_d = en_target_q;
        if (abort) err_timeout_d = 1'b1;
        if (state_d != state_q) cnt_d = '0;
        else if (wait_state)    cnt_d = cnt_q + WAIT_CNT_W'(1);
        else                    cnt_d = cnt_q;
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            cnt_q          <= '0;
            mfi_q          <= 8'd0;
            mfn_q          <= 8'd0;
            mfd_q          <= 8'd0;
            en_target_q    <= 1'b0;
            async_update_q <= 1'b0;
            async_enable_q <= 1'b0;
            err_cfg_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            mfi_q          <= mfi_d;
            mfn_q          <= mfn_d;
            mfd_q          <= mfd_d;
            en_target_q    <= en_target_d;
            async_update_q <= async_update_d;
            async_enable_q <= async_enable_d;
            err_cfg_q      <= err_cfg_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign mfi          = mfi_q;
    assign mfn          = mfn_q;
    assign mfd          = mfd_q;
    assign async_update = async_update_q;
    assign async_enable = async_enable_q;
    assign err_cfg      = err_cfg_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_clock_route_config_ctrl.sv
module tb_clock_route_config_ctrl;

    logic       clock = 1'b0;
    logic       async_resetn = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_mfi = 8'd0, cfg_mfn = 8'd0, cfg_mfd = 8'd0;
    logic       cfg_enable = 1'b0;
    logic [7:0] mfi, mfn, mfd;
    logic       async_update, async_update_ack;
    logic       async_enable, async_enable_ack;
    logic       busy, done, err_cfg, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    clock_route_config_ctrl #(.TIMEOUT_CYCLES(20)) dut (
        .clock            (clock),
        .async_resetn     (async_resetn),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_mfi          (cfg_mfi),
        .cfg_mfn          (cfg_mfn),
        .cfg_mfd          (cfg_mfd),
        .cfg_enable       (cfg_enable),
        .mfi              (mfi),
        .mfn              (mfn),
        .mfd              (mfd),
        .async_update     (async_update),
        .async_update_ack (async_update_ack),
        .async_enable     (async_enable),
        .async_enable_ack (async_enable_ack),
        .busy             (busy),
        .done             (done),
        .err_cfg          (err_cfg),
        .err_timeout      (err_timeout)
    );

    // Divider model: each acknowledge follows its request level 5 cycles later.
    logic [4:0] upd_sh = '0;
    logic [4:0] en_sh  = '0;
    logic       upd_block = 1'b0;
    always @(posedge clock) begin
        upd_sh <= {upd_sh[3:0], async_update & ~upd_block};
        en_sh  <= {en_sh[3:0], async_enable};
    end
    assign async_update_ack = upd_sh[4];
    assign async_enable_ack = en_sh[4];

    // Event counters sampled away from the active edge.
    int   done_cnt = 0;
    int   upd_rise_cnt = 0;
    logic upd_prev = 1'b0;
    always @(negedge clock) begin
        upd_prev <= async_update;
        if (async_update && !upd_prev) upd_rise_cnt <= upd_rise_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // Present one request for a single edge; returns at the negedge after that edge.
    task automatic send(input logic [7:0] i, input logic [7:0] n, input logic [7:0] d,
                        input logic e);
        @(negedge clock);
        cfg_mfi = i; cfg_mfn = n; cfg_mfd = d; cfg_enable = e; cfg_valid = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        async_resetn = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({cfg_ready, busy, done, async_update, async_enable, err_cfg, err_timeout}
            !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {cfg_ready, busy, done, async_update, async_enable, err_cfg, err_timeout});
        end
        n_tests++;
        if ({mfi, mfn, mfd} !== 24'h0) begin
            n_fail++; $display("FAIL reset_div: got %h expected 000000", {mfi, mfn, mfd});
        end
        async_resetn = 1'b1;
        @(negedge clock);
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", cfg_ready);
        end
    endtask

    task automatic test_invalid;
        int r0, d0;
        r0 = upd_rise_cnt; d0 = done_cnt;
        send(8'd0, 8'd0, 8'd0, 1'b1);
        n_tests++;
        if ({err_cfg, cfg_ready, busy} !== 3'b110) begin
            n_fail++; $display("FAIL inv_mfi0: got %b expected 110", {err_cfg, cfg_ready, busy});
        end
        repeat (3) @(negedge clock);
        n_tests++;
        if ({mfi, mfn, mfd, async_enable} !== 25'h0) begin
            n_fail++; $display("FAIL inv_mfi0_hold: got %h expected 0", {mfi, mfn, mfd});
        end
        send(8'd3, 8'd5, 8'd5, 1'b1);
        repeat (3) @(negedge clock);
        n_tests++;
        if ({err_cfg, cfg_ready, busy, mfi, mfn, mfd} !== {3'b110, 24'h0}) begin
            n_fail++;
            $display("FAIL inv_frac: got %b/%h expected 110/000000",
                     {err_cfg, cfg_ready, busy}, {mfi, mfn, mfd});
        end
        n_tests++;
        if ((upd_rise_cnt - r0) != 0 || (done_cnt - d0) != 0) begin
            n_fail++;
            $display("FAIL inv_no_seq: got upd=%0d done=%0d expected 0/0",
                     upd_rise_cnt - r0, done_cnt - d0);
        end
    endtask

    task automatic test_valid;
        int r0, d0, k, j;
        r0 = upd_rise_cnt; d0 = done_cnt;
        send(8'd4, 8'd1, 8'd3, 1'b1);
        n_tests++;
        if ({async_update, err_cfg, busy, cfg_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL val_start: got %b expected 1010",
                     {async_update, err_cfg, busy, cfg_ready});
        end
        k = 0;
        while (async_update && k < 50) begin @(negedge clock); k++; end
        j = 0;
        while (!done && j < 60) begin @(negedge clock); j++; end
        // Release, 5-cycle ack drop, 2-flop sync, EN_CHK, 7-cycle enable ack, EN_WAIT exit.
        n_tests++;
        if (j != 17) begin
            n_fail++; $display("FAIL val_latency: got %0d expected 17 cycles", j);
        end
        @(negedge clock);
        n_tests++;
        if ({done, cfg_ready, async_enable} !== 3'b011 || {mfi, mfn, mfd} !== 24'h040103) begin
            n_fail++;
            $display("FAIL val_end: got %b/%h expected 011/040103",
                     {done, cfg_ready, async_enable}, {mfi, mfn, mfd});
        end
        n_tests++;
        if ((upd_rise_cnt - r0) != 1 || (done_cnt - d0) != 1) begin
            n_fail++;
            $display("FAIL val_pulses: got upd=%0d done=%0d expected 1/1",
                     upd_rise_cnt - r0, done_cnt - d0);
        end
    endtask

    task automatic test_en_skip;
        int d0, k, j;
        bit dropped;
        d0 = done_cnt; dropped = 1'b0;
        send(8'd5, 8'd0, 8'd0, 1'b1);
        k = 0;
        while (async_update && k < 50) begin @(negedge clock); k++; end
        j = 0;
        while (!done && j < 60) begin
            @(negedge clock); j++;
            if (!async_enable) dropped = 1'b1;
        end
        n_tests++;
        if (j != 9) begin
            n_fail++; $display("FAIL skip_latency: got %0d expected 9 cycles", j);
        end
        @(negedge clock);
        n_tests++;
        if (dropped || async_enable !== 1'b1 || {mfi, mfn, mfd} !== 24'h050000
            || (done_cnt - d0) != 1) begin
            n_fail++;
            $display("FAIL skip_end: got en=%b drop=%b div=%h done=%0d expected 1/0/050000/1",
                     async_enable, dropped, {mfi, mfn, mfd}, done_cnt - d0);
        end
    endtask

    task automatic test_timeout;
        int d0, k;
        d0 = done_cnt;
        upd_block = 1'b1;
        send(8'd2, 8'd0, 8'd0, 1'b1);
        k = 0;
        while (!err_timeout && k < 100) begin @(negedge clock); k++; end
        n_tests++;
        if (k != 21) begin
            n_fail++; $display("FAIL to_latency: got %0d expected 21 cycles", k);
        end
        n_tests++;
        if ({async_update, cfg_ready, busy, async_enable} !== 4'b0101
            || {mfi, mfn, mfd} !== 24'h020000 || (done_cnt - d0) != 0) begin
            n_fail++;
            $display("FAIL to_state: got %b/%h done=%0d expected 0101/020000/0",
                     {async_update, cfg_ready, busy, async_enable}, {mfi, mfn, mfd},
                     done_cnt - d0);
        end
        upd_block = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int d0, j;
        bit moved;
        d0 = done_cnt; moved = 1'b0;
        @(negedge clock);
        cfg_mfi = 8'd6; cfg_mfn = 8'd2; cfg_mfd = 8'd7; cfg_enable = 1'b0; cfg_valid = 1'b1;
        @(negedge clock);
        cfg_mfi = 8'd7; cfg_mfn = 8'd0; cfg_mfd = 8'd0;
        n_tests++;
        if ({busy, err_timeout} !== 2'b10 || {mfi, mfn, mfd} !== 24'h060207) begin
            n_fail++;
            $display("FAIL b2b_first: got %b/%h expected 10/060207",
                     {busy, err_timeout}, {mfi, mfn, mfd});
        end
        j = 0;
        while (!done && j < 100) begin
            @(negedge clock); j++;
            if ({mfi, mfn, mfd} !== 24'h060207) moved = 1'b1;
        end
        n_tests++;
        if (!done || moved) begin
            n_fail++; $display("FAIL b2b_hold: got done=%b moved=%b expected 1/0", done, moved);
        end
        @(negedge clock);
        n_tests++;
        if ({cfg_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_idle: got %b expected 10", {cfg_ready, busy});
        end
        @(negedge clock);
        cfg_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || {mfi, mfn, mfd} !== 24'h070000) begin
            n_fail++;
            $display("FAIL b2b_second: got %b/%h expected 1/070000", busy, {mfi, mfn, mfd});
        end
        j = 0;
        while (!done && j < 100) begin @(negedge clock); j++; end
        @(negedge clock);
        n_tests++;
        if ((done_cnt - d0) != 2 || async_enable !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: got done=%0d en=%b rdy=%b expected 2/0/1",
                     done_cnt - d0, async_enable, cfg_ready);
        end
    endtask

    task automatic test_reset_mid;
        int d0, j;
        send(8'd3, 8'd1, 8'd2, 1'b1);
        j = 0;
        while (!async_enable && j < 100) begin @(negedge clock); j++; end
        d0 = done_cnt;
        @(negedge clock);
        #2 async_resetn = 1'b0;
        #1;
        n_tests++;
        if ({cfg_ready, busy, done, async_update, async_enable, err_cfg, err_timeout}
            !== 7'b1000000 || {mfi, mfn, mfd} !== 24'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b/%h expected 1000000/000000",
                     {cfg_ready, busy, done, async_update, async_enable, err_cfg, err_timeout},
                     {mfi, mfn, mfd});
        end
        repeat (3) @(negedge clock);
        async_resetn = 1'b1;
        repeat (12) @(negedge clock);
        n_tests++;
        if ((done_cnt - d0) != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_done: got done=%0d busy=%b expected 0/0", done_cnt - d0, busy);
        end
        d0 = done_cnt;
        send(8'd4, 8'd1, 8'd3, 1'b1);
        j = 0;
        while (!done && j < 100) begin @(negedge clock); j++; end
        @(negedge clock);
        n_tests++;
        if ((done_cnt - d0) != 1 || {mfi, mfn, mfd} !== 24'h040103 || async_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_recover: got done=%0d div=%h en=%b expected 1/040103/1",
                     done_cnt - d0, {mfi, mfn, mfd}, async_enable);
        end
    endtask

    initial begin
        test_reset;
        test_invalid;
        test_valid;
        test_en_skip;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
